// File: rtl/game_session_fsm_pkg.sv
// game_session_fsm_pkg: shared state encodings and default widths for the session sequencer
package game_session_fsm_pkg;
  localparam int SCORE_W_DEF = 10;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_OVER      = 3'd4
  } state_t;
endpackage

// File: rtl/game_session_fsm_press_debounce.sv
// press_debounce: one-cycle press strobe once raw is stably high; re-arms after a stable low
module press_debounce #(
  parameter int PRESS_MIN_CYC = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(PRESS_MIN_CYC + 1);
  logic [CW-1:0] cnt;
  logic level;
  logic done;
  // cnt tracks consecutive cycles where raw disagrees with the accepted level
  assign done = (raw != level) && (cnt == CW'(PRESS_MIN_CYC - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      cnt   <= (raw == level || done) ? '0 : cnt + 1'b1;
      level <= done ? raw : level;
      press <= done && raw;
    end
endmodule

// File: rtl/game_session_fsm.sv
// game_session_fsm: whack-a-mole session sequencer (countdown, play/pause, game over, high score)
module game_session_fsm
  import game_session_fsm_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int COUNTDOWN_S   = 3,
  parameter int OVER_HOLD_S   = 5,
  parameter int PRESS_MIN_CYC = 50_000,
  parameter int SCORE_W       = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_raw,
  input  logic               pause_raw,
  input  logic               game_over,
  input  logic [SCORE_W-1:0] score,
  output logic               game_rst_n,
  output logic               game_run,
  output logic [2:0]         state,
  output logic [3:0]         countdown,
  output logic [SCORE_W-1:0] final_score,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_record
);
  localparam int TW = $clog2(CLK_HZ + 1);
  state_t state_q, state_n;
  logic [TW-1:0] tick_cnt;
  logic [3:0] hold;
  logic start_p, pause_p, timing, tick, chg, over_in;

  press_debounce #(.PRESS_MIN_CYC(PRESS_MIN_CYC)) u_start_db (.clk(clk), .rst(rst), .raw(start_raw), .press(start_p));
  press_debounce #(.PRESS_MIN_CYC(PRESS_MIN_CYC)) u_pause_db (.clk(clk), .rst(rst), .raw(pause_raw), .press(pause_p));

  assign state   = state_q;
  assign timing  = (state_q == ST_COUNTDOWN) || (state_q == ST_OVER);
  assign tick    = timing && (tick_cnt == TW'(CLK_HZ - 1));
  assign chg     = state_n != state_q;
  assign over_in = chg && (state_n == ST_OVER);

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:      state_n = start_p ? ST_COUNTDOWN : ST_IDLE;
      ST_COUNTDOWN: state_n = (tick && countdown == 4'd1) ? ST_PLAY : ST_COUNTDOWN;
      ST_PLAY:      state_n = game_over ? ST_OVER : pause_p ? ST_PAUSE : ST_PLAY;
      ST_PAUSE:     state_n = game_over ? ST_OVER : pause_p ? ST_PLAY : ST_PAUSE;
      ST_OVER:      state_n = (start_p && hold == 4'(OVER_HOLD_S)) ? ST_COUNTDOWN : ST_OVER;
      default:      state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= ST_IDLE;
      tick_cnt    <= '0;
      hold        <= '0;
      countdown   <= '0;
      final_score <= '0;
      high_score  <= '0;
      new_record  <= 1'b0;
      game_rst_n  <= 1'b0;
      game_run    <= 1'b0;
    end else begin
      state_q     <= state_n;
      tick_cnt    <= (chg || !timing || tick) ? '0 : tick_cnt + 1'b1;
      hold        <= chg ? '0 : (state_q == ST_OVER && tick && hold != 4'(OVER_HOLD_S)) ? hold + 1'b1 : hold;
      countdown   <= (chg && state_n == ST_COUNTDOWN) ? 4'(COUNTDOWN_S) :
                     (state_q == ST_COUNTDOWN && tick) ? countdown - 1'b1 : countdown;
      final_score <= over_in ? score : final_score;
      high_score  <= (over_in && score > high_score) ? score : high_score;
      new_record  <= over_in ? (score > high_score) : chg ? 1'b0 : new_record;
      game_rst_n  <= (state_n == ST_PLAY) || (state_n == ST_PAUSE) || (state_n == ST_OVER);
      game_run    <= state_n == ST_PLAY;
    end
endmodule

// File: tb/tb_game_session_fsm.sv
// tb_game_session_fsm: scoreboard bench for the session sequencer with directed vectors
module tb_game_session_fsm;
  logic clk = 1'b0;
  logic rst, start_raw, pause_raw, game_over;
  logic [9:0] score;
  logic game_rst_n, game_run, new_record;
  logic [2:0] state;
  logic [3:0] countdown;
  logic [9:0] final_score, high_score;
  int n_cmp = 0;
  int n_bad = 0;
  int strobes = 0;

  typedef struct {
    string name;
    logic [29:0] v;
  } exp_t;
  exp_t q[$];

  game_session_fsm #(.CLK_HZ(10), .COUNTDOWN_S(3), .OVER_HOLD_S(2), .PRESS_MIN_CYC(4), .SCORE_W(10)) dut (
    .clk(clk), .rst(rst), .start_raw(start_raw), .pause_raw(pause_raw), .game_over(game_over),
    .score(score), .game_rst_n(game_rst_n), .game_run(game_run), .state(state), .countdown(countdown),
    .final_score(final_score), .high_score(high_score), .new_record(new_record)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dut.u_start_db.press) strobes++;

  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      logic [29:0] act;
      e = q.pop_front();
      act = {state, countdown, game_rst_n, game_run, final_score, high_score, new_record};
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got st=%0d cd=%0d rst_n=%b run=%b fs=%0d hs=%0d nr=%b, want st=%0d cd=%0d rst_n=%b run=%b fs=%0d hs=%0d nr=%b",
                 e.name, act[29:27], act[26:23], act[22], act[21], act[20:11], act[10:1], act[0],
                 e.v[29:27], e.v[26:23], e.v[22], e.v[21], e.v[20:11], e.v[10:1], e.v[0]);
      end
    end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_o(input string name, input int st, input int cd, input int rn, input int run,
                          input int fs, input int hs, input int nr);
    exp_t e;
    e.name = name;
    e.v = {3'(st), 4'(cd), 1'(rn), 1'(run), 10'(fs), 10'(hs), 1'(nr)};
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; start_raw = 1'b0; pause_raw = 1'b0; game_over = 1'b0; score = '0;
    step(1);
    expect_o("reset", 0, 0, 0, 0, 0, 0, 0);
    step(1);
    rst = 1'b0;
    step(1);
    // short touch must not register
    start_raw = 1'b1; step(3); start_raw = 1'b0; step(5);
    expect_o("short_press", 0, 0, 0, 0, 0, 0, 0);
    start_raw = 1'b1; step(5);
    expect_o("cd_entry", 1, 3, 0, 0, 0, 0, 0);
    step(1); start_raw = 1'b0; step(8);
    expect_o("cd_3_hold", 1, 3, 0, 0, 0, 0, 0);
    n_cmp++;
    if (strobes != 1) begin
      n_bad++;
      $display("FAIL one_strobe: got %0d strobes, want 1", strobes);
    end
    step(1);  expect_o("cd_2", 1, 2, 0, 0, 0, 0, 0);
    step(10); expect_o("cd_1", 1, 1, 0, 0, 0, 0, 0);
    step(9);  expect_o("cd_1_last", 1, 1, 0, 0, 0, 0, 0);
    step(1);  expect_o("play_at_30", 2, 0, 1, 1, 0, 0, 0);
    // pause toggling, then pause strobe coinciding with game_over
    pause_raw = 1'b1; step(5); expect_o("pause", 3, 0, 1, 0, 0, 0, 0);
    pause_raw = 1'b0; step(5); expect_o("pause_hold", 3, 0, 1, 0, 0, 0, 0);
    pause_raw = 1'b1; step(5); expect_o("resume", 2, 0, 1, 1, 0, 0, 0);
    pause_raw = 1'b0; step(5);
    pause_raw = 1'b1; step(4);
    game_over = 1'b1; score = 10'd37;
    step(1); expect_o("over_record", 4, 0, 1, 0, 37, 37, 1);
    pause_raw = 1'b0; game_over = 1'b0;
    step(1); start_raw = 1'b1; step(6);
    expect_o("early_start", 4, 0, 1, 0, 37, 37, 1);
    start_raw = 1'b0; step(14);
    start_raw = 1'b1; step(5);
    expect_o("restart", 1, 3, 0, 0, 37, 37, 0);
    start_raw = 1'b0; step(30);
    expect_o("play2", 2, 0, 1, 1, 37, 37, 0);
    game_over = 1'b1; step(1);
    expect_o("over_tie", 4, 0, 1, 0, 37, 37, 0);
    game_over = 1'b0; step(20);
    start_raw = 1'b1; step(5);
    expect_o("restart2", 1, 3, 0, 0, 37, 37, 0);
    start_raw = 1'b0; step(30);
    expect_o("play3", 2, 0, 1, 1, 37, 37, 0);
    step(3);
    rst = 1'b1; #1;
    expect_o("rst_mid_game", 0, 0, 0, 0, 0, 0, 0);
    step(1); rst = 1'b0; step(2);
    expect_o("idle_after_rst", 0, 0, 0, 0, 0, 0, 0);
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
